// File: rtl/lb_status_regs_if.sv
// Local-bus port bundle shared by the status register bank and its bus master.
// The master drives the strobe, address and write data; the slave returns registered read data.
interface lb_status_regs_if #(
    parameter int AW = 24,
    parameter int DW = 32
);
    logic          lb_valid;
    logic          lb_rnw;
    logic [AW-1:0] lb_addr;
    logic [DW-1:0] lb_wdata;
    logic          lb_renable;
    logic [DW-1:0] lb_rdata;

    modport master (
        output lb_valid,
        output lb_rnw,
        output lb_addr,
        output lb_wdata,
        output lb_renable,
        input  lb_rdata
    );

    modport slave (
        input  lb_valid,
        input  lb_rnw,
        input  lb_addr,
        input  lb_wdata,
        input  lb_renable,
        output lb_rdata
    );
endinterface

// File: rtl/lb_status_regs.sv
// Ethernet bridge local-bus register bank: ID, scratch, LED control, link status,
// saturating packet counters, uptime, and a pass-through window to an external block.
module lb_status_regs #(
    parameter int          AW       = 24,
    parameter int          DW       = 32,
    parameter logic [31:0] BUILD_ID = 32'h6765_7431,
    parameter logic [AW-1:0] EXT_BASE = AW'(24'h01_0000)
) (
    input  logic                lb_clk,
    input  logic                reset,
    lb_status_regs_if.slave     lb,
    input  logic                rx_mon,
    input  logic                tx_mon,
    input  logic [6:0]          an_status,
    input  logic                gt_locked,
    output logic [AW-1:0]       ext_addr,
    output logic                ext_renable,
    input  logic [DW-1:0]       ext_rdata,
    output logic [3:0]          led_out,
    input  logic [3:0]          led_default
);

    typedef enum logic [2:0] {
        REG_ID       = 3'd0,
        REG_SCRATCH  = 3'd1,
        REG_CTRL     = 3'd2,
        REG_STATUS   = 3'd3,
        REG_RX_CNT   = 3'd4,
        REG_TX_CNT   = 3'd5,
        REG_UPTIME   = 3'd6,
        REG_UNMAPPED = 3'd7
    } reg_sel_e;

    localparam logic [31:0] UNMAPPED_WORD = 32'hDEAD_0BAD;

    // Architectural state
    logic [DW-1:0] scratch_d,  scratch_q;
    logic          led_ovr_d,  led_ovr_q;
    logic [3:0]    led_val_d,  led_val_q;
    logic [7:0]    status_d,   status_q;
    logic          rx_prev_d,  rx_prev_q;
    logic          tx_prev_d,  tx_prev_q;
    logic [31:0]   rx_cnt_d,   rx_cnt_q;
    logic [31:0]   tx_cnt_d,   tx_cnt_q;
    logic [31:0]   uptime_d,   uptime_q;
    logic [3:0]    led_out_d,  led_out_q;

    // Read pipeline
    logic          rd_vld_d,   rd_vld_q;
    logic          rd_ext_d,   rd_ext_q;
    logic [DW-1:0] rd_data_d,  rd_data_q;
    logic [DW-1:0] lb_rdata_d, lb_rdata_q;

    // Decode
    reg_sel_e      sel;
    logic          is_ext;
    logic          wr_en;
    logic          rd_en;
    logic          cnt_clr;
    logic          rx_evt;
    logic          tx_evt;
    logic [DW-1:0] rd_word;

    assign ext_addr    = lb.lb_addr - EXT_BASE;
    assign ext_renable = lb.lb_renable;
    assign lb.lb_rdata = lb_rdata_q;
    assign led_out     = led_out_q;

    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path can leave it unassigned and infer a latch.
        is_ext = (lb.lb_addr >= EXT_BASE);
        sel    = REG_UNMAPPED;
        if (!is_ext && (lb.lb_addr < AW'(8))) begin
            sel = reg_sel_e'(lb.lb_addr[2:0]);
        end
        wr_en   = lb.lb_valid & ~lb.lb_rnw & ~is_ext;
        rd_en   = lb.lb_valid &  lb.lb_rnw;
        cnt_clr = wr_en && (sel == REG_CTRL) && lb.lb_wdata[8];
    end

    // Register writes and counters
    always_comb begin
        scratch_d = scratch_q;
        led_ovr_d = led_ovr_q;
        led_val_d = led_val_q;
        if (wr_en && (sel == REG_SCRATCH)) begin
            scratch_d = lb.lb_wdata;
        end
        if (wr_en && (sel == REG_CTRL)) begin
            led_ovr_d = lb.lb_wdata[0];
            led_val_d = lb.lb_wdata[4:1];
        end

        status_d  = {gt_locked, an_status};
        rx_prev_d = rx_mon;
        tx_prev_d = tx_mon;
        rx_evt    = rx_mon & ~rx_prev_q;
        tx_evt    = tx_mon & ~tx_prev_q;

        // A clear in the same cycle as a packet edge drops that packet.
        rx_cnt_d = rx_cnt_q;
        tx_cnt_d = tx_cnt_q;
        if (cnt_clr) begin
            rx_cnt_d = '0;
            tx_cnt_d = '0;
        end else begin
            if (rx_evt && (rx_cnt_q != '1)) rx_cnt_d = rx_cnt_q + 32'd1;
            if (tx_evt && (tx_cnt_q != '1)) tx_cnt_d = tx_cnt_q + 32'd1;
        end
        uptime_d = cnt_clr ? '0 : uptime_q + 32'd1;

        led_out_d = led_ovr_q ? led_val_q : led_default;
    end

    // Read data selection and two-stage read pipeline
    always_comb begin
        rd_word = UNMAPPED_WORD;
        unique case (sel)
            REG_ID:       rd_word = BUILD_ID;
            REG_SCRATCH:  rd_word = scratch_q;
            REG_CTRL:     rd_word = {27'b0, led_val_q, led_ovr_q};
            REG_STATUS:   rd_word = {23'b0, status_q[7], 1'b0, status_q[6:0]};
            REG_RX_CNT:   rd_word = rx_cnt_q;
            REG_TX_CNT:   rd_word = tx_cnt_q;
            REG_UPTIME:   rd_word = uptime_q;
            REG_UNMAPPED: rd_word = UNMAPPED_WORD;
            default:      rd_word = UNMAPPED_WORD;
        endcase

        rd_vld_d  = rd_en;
        rd_ext_d  = is_ext;
        rd_data_d = rd_en ? rd_word : rd_data_q;

        // External data is only sampled here, one cycle after its address was presented.
        lb_rdata_d = lb_rdata_q;
        if (rd_vld_q) begin
            lb_rdata_d = rd_ext_q ? ext_rdata : rd_data_q;
        end
    end

    always_ff @(posedge lb_clk or posedge reset) begin
        if (reset) begin
            scratch_q  <= '0;
            led_ovr_q  <= 1'b0;
            led_val_q  <= '0;
            status_q   <= '0;
            rx_prev_q  <= 1'b0;
            tx_prev_q  <= 1'b0;
            rx_cnt_q   <= '0;
            tx_cnt_q   <= '0;
            uptime_q   <= '0;
            led_out_q  <= '0;
            rd_vld_q   <= 1'b0;
            rd_ext_q   <= 1'b0;
            rd_data_q  <= '0;
            lb_rdata_q <= '0;
        end else begin
            // NOTE: non-blocking assignments let every flop sample the pre-edge values, independent of statement order.
            scratch_q  <= scratch_d;
            led_ovr_q  <= led_ovr_d;
            led_val_q  <= led_val_d;
            status_q   <= status_d;
            rx_prev_q  <= rx_prev_d;
            tx_prev_q  <= tx_prev_d;
            rx_cnt_q   <= rx_cnt_d;
            tx_cnt_q   <= tx_cnt_d;
            uptime_q   <= uptime_d;
            led_out_q  <= led_out_d;
            rd_vld_q   <= rd_vld_d;
            rd_ext_q   <= rd_ext_d;
            rd_data_q  <= rd_data_d;
            lb_rdata_q <= lb_rdata_d;
        end
    end

endmodule

// File: tb/tb_lb_status_regs.sv
// Directed self-checking bench for lb_status_regs: register map, read pipeline,
// counters, LED override, external window and reset during a read.
module tb_lb_status_regs;

    localparam int          AW       = 24;
    localparam int          DW       = 32;
    localparam logic [31:0] BUILD_ID = 32'h6765_7431;
    localparam logic [23:0] EXT_BASE = 24'h01_0000;

    logic          lb_clk;
    logic          reset;
    logic          rx_mon;
    logic          tx_mon;
    logic [6:0]    an_status;
    logic          gt_locked;
    logic [AW-1:0] ext_addr;
    logic          ext_renable;
    logic [DW-1:0] ext_rdata;
    logic [3:0]    led_out;
    logic [3:0]    led_default;

    int checks;
    int failures;

    lb_status_regs_if #(.AW(AW), .DW(DW)) lb_if ();

    lb_status_regs #(
        .AW(AW), .DW(DW), .BUILD_ID(BUILD_ID), .EXT_BASE(EXT_BASE)
    ) dut (
        .lb_clk      (lb_clk),
        .reset       (reset),
        .lb          (lb_if.slave),
        .rx_mon      (rx_mon),
        .tx_mon      (tx_mon),
        .an_status   (an_status),
        .gt_locked   (gt_locked),
        .ext_addr    (ext_addr),
        .ext_renable (ext_renable),
        .ext_rdata   (ext_rdata),
        .led_out     (led_out),
        .led_default (led_default)
    );

    initial begin
        lb_clk = 1'b0;
        forever #5 lb_clk = ~lb_clk;
    end

    task automatic bus_write(input logic [AW-1:0] addr, input logic [DW-1:0] data);
        @(negedge lb_clk);
        lb_if.lb_valid = 1'b1;
        lb_if.lb_rnw   = 1'b0;
        lb_if.lb_addr  = addr;
        lb_if.lb_wdata = data;
        @(negedge lb_clk);
        lb_if.lb_valid = 1'b0;
    endtask

    task automatic bus_read(input logic [AW-1:0] addr, output logic [DW-1:0] data);
        @(negedge lb_clk);
        lb_if.lb_valid = 1'b1;
        lb_if.lb_rnw   = 1'b1;
        lb_if.lb_addr  = addr;
        @(negedge lb_clk);
        lb_if.lb_valid = 1'b0;
        @(negedge lb_clk);
        data = lb_if.lb_rdata;
    endtask

    task automatic pulse_rx(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge lb_clk);
            rx_mon = 1'b1;
            @(negedge lb_clk);
            rx_mon = 1'b0;
        end
    endtask

    task automatic test_reset();
        logic [DW-1:0] d;
        checks++;
        if (lb_if.lb_rdata !== 32'h0) begin
            failures++;
            $display("FAIL reset_rdata got=%h exp=%h", lb_if.lb_rdata, 32'h0);
        end
        checks++;
        if (led_out !== 4'h0) begin
            failures++;
            $display("FAIL reset_led got=%h exp=%h", led_out, 4'h0);
        end
        @(negedge lb_clk);
        reset = 1'b0;
        bus_read(24'h0, d);
        checks++;
        if (d !== 32'h6765_7431) begin
            failures++;
            $display("FAIL read_id got=%h exp=%h", d, 32'h6765_7431);
        end
        bus_read(24'h5, d);
        checks++;
        if (d !== 32'h0) begin
            failures++;
            $display("FAIL read_tx_reset got=%h exp=%h", d, 32'h0);
        end
        bus_read(24'h9, d);
        checks++;
        if (d !== 32'hDEAD_0BAD) begin
            failures++;
            $display("FAIL read_unmapped9 got=%h exp=%h", d, 32'hDEAD_0BAD);
        end
        bus_read(24'h7, d);
        checks++;
        if (d !== 32'hDEAD_0BAD) begin
            failures++;
            $display("FAIL read_unmapped7 got=%h exp=%h", d, 32'hDEAD_0BAD);
        end
        bus_read(24'h1, d);
        checks++;
        if (d !== 32'h0) begin
            failures++;
            $display("FAIL read_scratch_reset got=%h exp=%h", d, 32'h0);
        end
    endtask

    task automatic test_scratch();
        logic [DW-1:0] d;
        // Write followed immediately by a read of the same register.
        @(negedge lb_clk);
        lb_if.lb_valid = 1'b1;
        lb_if.lb_rnw   = 1'b0;
        lb_if.lb_addr  = 24'h1;
        lb_if.lb_wdata = 32'hA5A5_1234;
        @(negedge lb_clk);
        lb_if.lb_rnw   = 1'b1;
        @(negedge lb_clk);
        lb_if.lb_valid = 1'b0;
        @(negedge lb_clk);
        checks++;
        if (lb_if.lb_rdata !== 32'hA5A5_1234) begin
            failures++;
            $display("FAIL raw_scratch got=%h exp=%h", lb_if.lb_rdata, 32'hA5A5_1234);
        end
        bus_write(24'h0, 32'h1111_2222);
        bus_read(24'h0, d);
        checks++;
        if (d !== BUILD_ID) begin
            failures++;
            $display("FAIL id_write_ignored got=%h exp=%h", d, BUILD_ID);
        end
        bus_write(EXT_BASE + 24'h1, 32'h0BAD_BEEF);
        bus_read(24'h1, d);
        checks++;
        if (d !== 32'hA5A5_1234) begin
            failures++;
            $display("FAIL scratch_hold got=%h exp=%h", d, 32'hA5A5_1234);
        end
    endtask

    task automatic test_back_to_back();
        logic [AW-1:0] addrs [4];
        logic [DW-1:0] res   [4];
        addrs[0] = 24'h0;
        addrs[1] = 24'h1;
        addrs[2] = 24'h6;
        addrs[3] = 24'h6;
        for (int i = 0; i < 6; i++) begin
            @(negedge lb_clk);
            if (i >= 2) res[i-2] = lb_if.lb_rdata;
            if (i < 4) begin
                lb_if.lb_valid = 1'b1;
                lb_if.lb_rnw   = 1'b1;
                lb_if.lb_addr  = addrs[i];
            end else begin
                lb_if.lb_valid = 1'b0;
            end
        end
        checks++;
        if (res[0] !== BUILD_ID) begin
            failures++;
            $display("FAIL b2b_id got=%h exp=%h", res[0], BUILD_ID);
        end
        checks++;
        if (res[1] !== 32'hA5A5_1234) begin
            failures++;
            $display("FAIL b2b_scratch got=%h exp=%h", res[1], 32'hA5A5_1234);
        end
        checks++;
        if (res[3] - res[2] !== 32'd1) begin
            failures++;
            $display("FAIL b2b_uptime_step got=%h exp=%h", res[3] - res[2], 32'd1);
        end
    endtask

    task automatic test_status();
        logic [DW-1:0] d;
        @(negedge lb_clk);
        an_status = 7'h55;
        gt_locked = 1'b1;
        bus_read(24'h3, d);
        checks++;
        if (d !== 32'h0000_0155) begin
            failures++;
            $display("FAIL status got=%h exp=%h", d, 32'h0000_0155);
        end
    endtask

    task automatic test_counters();
        logic [DW-1:0] d;
        pulse_rx(5);
        @(negedge lb_clk);
        tx_mon = 1'b1;
        repeat (10) @(negedge lb_clk);
        tx_mon = 1'b0;
        bus_read(24'h4, d);
        checks++;
        if (d !== 32'd5) begin
            failures++;
            $display("FAIL rx_cnt got=%h exp=%h", d, 32'd5);
        end
        bus_read(24'h5, d);
        checks++;
        if (d !== 32'd1) begin
            failures++;
            $display("FAIL tx_cnt got=%h exp=%h", d, 32'd1);
        end
        // Preload near the top so saturation can be reached in a few pulses.
        @(negedge lb_clk);
        force dut.rx_cnt_q = 32'hFFFF_FFFE;
        @(posedge lb_clk);
        #1 release dut.rx_cnt_q;
        pulse_rx(3);
        bus_read(24'h4, d);
        checks++;
        if (d !== 32'hFFFF_FFFF) begin
            failures++;
            $display("FAIL rx_saturate got=%h exp=%h", d, 32'hFFFF_FFFF);
        end
    endtask

    task automatic test_clear();
        logic [DW-1:0] d;
        @(negedge lb_clk);
        lb_if.lb_valid = 1'b1;
        lb_if.lb_rnw   = 1'b0;
        lb_if.lb_addr  = 24'h2;
        lb_if.lb_wdata = 32'h0000_0101;
        rx_mon         = 1'b1;
        @(negedge lb_clk);
        rx_mon         = 1'b0;
        lb_if.lb_rnw   = 1'b1;
        lb_if.lb_addr  = 24'h6;
        @(negedge lb_clk);
        lb_if.lb_valid = 1'b0;
        @(negedge lb_clk);
        checks++;
        if (lb_if.lb_rdata !== 32'h0) begin
            failures++;
            $display("FAIL uptime_clear got=%h exp=%h", lb_if.lb_rdata, 32'h0);
        end
        bus_read(24'h4, d);
        checks++;
        if (d !== 32'h0) begin
            failures++;
            $display("FAIL rx_clear_wins got=%h exp=%h", d, 32'h0);
        end
        bus_read(24'h5, d);
        checks++;
        if (d !== 32'h0) begin
            failures++;
            $display("FAIL tx_clear got=%h exp=%h", d, 32'h0);
        end
        bus_read(24'h2, d);
        checks++;
        if (d !== 32'h1) begin
            failures++;
            $display("FAIL ctrl_read got=%h exp=%h", d, 32'h1);
        end
        checks++;
        if (led_out !== 4'h0) begin
            failures++;
            $display("FAIL led_ovr_on got=%h exp=%h", led_out, 4'h0);
        end
    endtask

    task automatic test_led();
        bus_write(24'h2, 32'h0000_0015);
        checks++;
        if (led_out !== 4'h0) begin
            failures++;
            $display("FAIL led_early got=%h exp=%h", led_out, 4'h0);
        end
        @(negedge lb_clk);
        checks++;
        if (led_out !== 4'hA) begin
            failures++;
            $display("FAIL led_override got=%h exp=%h", led_out, 4'hA);
        end
        bus_write(24'h2, 32'h0);
        @(negedge lb_clk);
        checks++;
        if (led_out !== 4'h3) begin
            failures++;
            $display("FAIL led_default got=%h exp=%h", led_out, 4'h3);
        end
    endtask

    task automatic test_ext_and_reset();
        @(negedge lb_clk);
        lb_if.lb_valid   = 1'b1;
        lb_if.lb_rnw     = 1'b1;
        lb_if.lb_addr    = EXT_BASE + 24'h5;
        lb_if.lb_renable = 1'b1;
        #1;
        checks++;
        if (ext_addr !== 24'h5) begin
            failures++;
            $display("FAIL ext_addr got=%h exp=%h", ext_addr, 24'h5);
        end
        checks++;
        if (ext_renable !== 1'b1) begin
            failures++;
            $display("FAIL ext_renable got=%b exp=%b", ext_renable, 1'b1);
        end
        @(negedge lb_clk);
        lb_if.lb_valid   = 1'b0;
        lb_if.lb_renable = 1'b0;
        ext_rdata        = 32'hCAFE_F00D;
        @(negedge lb_clk);
        ext_rdata        = 32'h0;
        checks++;
        if (lb_if.lb_rdata !== 32'hCAFE_F00D) begin
            failures++;
            $display("FAIL ext_rdata got=%h exp=%h", lb_if.lb_rdata, 32'hCAFE_F00D);
        end
        // Reset lands between stage 1 and stage 2 of an ID read.
        lb_if.lb_valid = 1'b1;
        lb_if.lb_addr  = 24'h0;
        @(negedge lb_clk);
        lb_if.lb_valid = 1'b0;
        reset          = 1'b1;
        #1;
        checks++;
        if (lb_if.lb_rdata !== 32'h0) begin
            failures++;
            $display("FAIL reset_midread got=%h exp=%h", lb_if.lb_rdata, 32'h0);
        end
        @(negedge lb_clk);
        reset = 1'b0;
        repeat (2) @(negedge lb_clk);
        checks++;
        if (lb_if.lb_rdata !== 32'h0) begin
            failures++;
            $display("FAIL reset_dropped got=%h exp=%h", lb_if.lb_rdata, 32'h0);
        end
    endtask

    initial begin
        checks           = 0;
        failures         = 0;
        reset            = 1'b1;
        rx_mon           = 1'b0;
        tx_mon           = 1'b0;
        an_status        = 7'h0;
        gt_locked        = 1'b0;
        ext_rdata        = 32'h0;
        led_default      = 4'h3;
        lb_if.lb_valid   = 1'b0;
        lb_if.lb_rnw     = 1'b0;
        lb_if.lb_addr    = '0;
        lb_if.lb_wdata   = '0;
        lb_if.lb_renable = 1'b0;
        repeat (3) @(negedge lb_clk);

        test_reset();
        test_scratch();
        test_back_to_back();
        test_status();
        test_counters();
        test_clear();
        test_led();
        test_ext_and_reset();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
